// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous display update.
// Define SEG_BLANK_EN to blank leading-zero digits 3..1; the default build shows all digits.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES  = 20000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  dp_in,
  output logic        wr_ack,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  digit_sel,
  output logic        frame_start
);

  localparam int unsigned      CW        = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0]    LAST_CNT  = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0]    GUARD_CNT = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt_q,       cnt_d;
  logic [1:0]    digit_q,     digit_d;
  logic [15:0]   active_q,    active_d;
  logic [15:0]   pend_q,      pend_d;
  logic          pend_vld_q,  pend_vld_d;
  logic          wr_ack_q,    wr_ack_d;
  logic [3:0]    an_q,        an_d;
  logic [7:0]    seg_q,       seg_d;
  logic [1:0]    digit_sel_q, digit_sel_d;

  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nibble;
  logic          lit;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    cnt_d      = cnt_q + 1'b1;
    digit_d    = digit_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wr_ack_d   = wr_en;

    slot_end  = (cnt_q == LAST_CNT);
    frame_end = slot_end && (digit_q == 2'd3);

    if (slot_end) begin
      cnt_d   = '0;
      digit_d = digit_q + 1'b1;
    end

    // Commit before accepting the new write so a boundary write waits one more frame.
    if (frame_end && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end

    if (wr_en) begin
      pend_d     = wr_data;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    nibble      = active_q[{digit_q, 2'b00} +: 4];
    digit_sel_d = digit_q;
    lit         = (cnt_q >= GUARD_CNT);
`ifdef SEG_BLANK_EN
    case (digit_q)
      2'd3:    lit = lit && !((active_q[15:12] == 4'h0)  && !dp_in[3]);
      2'd2:    lit = lit && !((active_q[15:8]  == 8'h00) && !dp_in[2]);
      2'd1:    lit = lit && !((active_q[15:4]  == 12'h0) && !dp_in[1]);
      default: lit = lit;
    endcase
`endif
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (lit) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = {~dp_in[digit_q], hex7(nibble)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      digit_q     <= 2'd0;
      active_q    <= 16'h0000;
      // NOTE: pending data is cleared with its valid bit so a discarded write leaves no residue.
      pend_q      <= 16'h0000;
      pend_vld_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
      digit_sel_q <= 2'd0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the same pre-edge values.
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      wr_ack_q    <= wr_ack_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_end;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 20000, clock cycles each digit slot is held (legal range 4..2^24).
REQ-002 Parameter GUARD_CYCLES, default 2, cycles at each slot start with all digits off (anti-ghosting, legal 0..SCAN_CYCLES-2).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wr_en  in  1  write strobe for new display value.
REQ-006 wr_data  in  16  four hex nibbles, digit i = wr_data[4i+3:4i].
REQ-007 dp_in  in  4  decimal point per digit, sampled every cycle, 1 = lit.
REQ-008 wr_ack  out  1  one-cycle pulse acknowledging a write.
REQ-009 an  out  4  digit enables, active-low, an[i] drives digit i.
REQ-010 seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-011 digit_sel  out  2  index of digit currently scanned.
REQ-012 frame_start  out  1  one-cycle pulse when scan wraps digit 3 -> 0.

Function
REQ-013 Slot counter SHALL count 0..SCAN_CYCLES-1 then wrap to 0; digit index SHALL increment (mod 4) on each wrap.
REQ-014 frame_start SHALL pulse in the cycle the digit index changes 3 -> 0 and at no other time.
REQ-015 wr_en=1 SHALL load wr_data into a pending register and set pending-valid; wr_ack SHALL pulse exactly one cycle later.
REQ-016 A write while pending-valid=1 SHALL overwrite pending data (latest wins) and still be acked.
REQ-017 On the frame boundary (frame_start cycle), if pending-valid=1, pending data SHALL be copied into the active register and pending-valid cleared; display never changes mid-frame.
REQ-018 A write coinciding with a frame boundary SHALL commit the previously pending value (if any) now and hold the new write pending for the next boundary.
REQ-019 an, seg, digit_sel SHALL be registered: they reflect the slot state of the previous cycle (1-cycle latency).
REQ-020 During slot counts 0..GUARD_CYCLES-1, an SHALL be 4'hF; otherwise an SHALL be all ones except bit digit_sel low.
REQ-021 seg[6:0] SHALL be the active-low hex decode of active nibble digit_sel (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110, standard glyphs for all 16 values); seg[7] = ~dp_in[digit_sel].
REQ-022 While an = 4'hF, seg SHALL be 8'hFF.

Reset
REQ-023 rst=1 SHALL set slot counter 0, digit index 0, active 16'h0000, pending-valid 0, wr_ack 0, frame_start 0, digit_sel 0, an 4'hF, seg 8'hFF on the next edge.
REQ-024 rst asserted mid-slot or with a write pending SHALL discard the pending write and its ack; scanning SHALL restart at digit 0 after release.
REQ-025 A wr_en sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-026 Macro SEG_BLANK_EN defined: digit i (i=3,2,1) SHALL be blanked (an[i] held high, seg 8'hFF) when active nibbles i..3 are all zero and dp_in[i]=0; digit 0 always shown.
REQ-027 SEG_BLANK_EN undefined: all four digits SHALL be shown, zeros included; no blanking logic present.

Verification (SCAN_CYCLES=8, GUARD_CYCLES=2)
REQ-028 Reset release, no writes -> an cycles 4'hE,4'hD,4'hB,4'h7 each for 6 of 8 cycles, 4'hF for 2; seg 8'hC0 when on; frame_start every 32 cycles.
REQ-029 Mid-frame write 16'h1234 -> wr_ack next cycle; display unchanged until next frame_start, then digit0=4 (8'h99), digit3=1 (8'hF9).
REQ-030 Writes 16'hAAAA then 16'h5555 in same frame -> both acked; next frame shows 5555 only.
REQ-031 Write 16'hBEEF on frame_start cycle with 16'h1234 pending -> 1234 shown this frame, BEEF next frame.
REQ-032 rst pulse for 1 cycle during digit 2 with write pending -> outputs 8'hFF/4'hF, active 0000, pending write never displayed, no wr_ack.
REQ-033 SEG_BLANK_EN defined, value 16'h0007, dp_in=0 -> only an[0] ever low; value 16'h0000 -> digit0 shows 0.
